// File: rtl/exception_ctrl_pkg.sv
// Shared constants and types for the MEM-stage exception controller.
package exception_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h0000_0020;
  localparam int          DRAIN_CYCLES_DEFAULT = 1;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_CODE_INT  = 5'h00;
  localparam logic [4:0] EXC_CODE_SYS  = 5'h08;
  localparam logic [4:0] EXC_CODE_RI   = 5'h0a;
  localparam logic [4:0] EXC_CODE_OV   = 5'h0c;
  localparam logic [4:0] EXC_CODE_TR   = 5'h0d;

  localparam int EXC_BIT_SYSCALL = 0;
  localparam int EXC_BIT_RI      = 1;
  localparam int EXC_BIT_TRAP    = 2;
  localparam int EXC_BIT_OV      = 3;
  localparam int EXC_BIT_ERET    = 4;

  // Cause bits software may write with mtc0: IP1..IP0, IV, WP.
  localparam logic [31:0] CAUSE_WRITE_MASK = 32'h00C0_0300;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/exception_ctrl_cp0_fwd.sv
// Forwards a pending WB-stage mtc0 onto the CP0 status/cause/epc values.
module cp0_fwd
  import exception_ctrl_pkg::*;
(
  input  logic [31:0] status_in,
  input  logic [31:0] cause_in,
  input  logic [31:0] epc_in,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_data,
  output logic [31:0] status_eff,
  output logic [31:0] cause_eff,
  output logic [31:0] epc_eff
);

  // Pick the in-flight mtc0 value over the stale register where they collide.
  always_comb begin
    status_eff = status_in;
    cause_eff  = cause_in;
    epc_eff    = epc_in;
    if (wb_we) begin
      case (wb_waddr)
        CP0_REG_STATUS: status_eff = wb_data;
        CP0_REG_CAUSE:  cause_eff  = (cause_in & ~CAUSE_WRITE_MASK) | (wb_data & CAUSE_WRITE_MASK);
        CP0_REG_EPC:    epc_eff    = wb_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception/interrupt controller: prioritises events, issues a
// registered one-cycle flush with the redirect PC and CP0 commit, then drains.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_is_delayslot_i,
  input  logic [4:0]  mem_exc_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        exc_we_o,
  output logic [4:0]  exc_code_o,
  output logic        exc_epc_we_o,
  output logic [31:0] exc_epc_o,
  output logic        exc_bd_o,
  output logic        eret_o,
  output logic        busy_o
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  state_t      state, state_next;
  logic [2:0]  drain_count;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        exl, irq_pending, take_exc, take_eret;
  logic [4:0]  code_sel;

  logic        flush_nxt, eret_nxt, exc_we_nxt, epc_we_nxt, bd_nxt;
  logic [31:0] new_pc_nxt, epc_nxt;
  logic [4:0]  code_nxt;

  logic        unused_bits;
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

  cp0_fwd u_cp0_fwd (
    .status_in  (cp0_status_i),
    .cause_in   (cp0_cause_i),
    .epc_in     (cp0_epc_i),
    .wb_we      (wb_cp0_we_i),
    .wb_waddr   (wb_cp0_waddr_i),
    .wb_data    (wb_cp0_data_i),
    .status_eff (status_eff),
    .cause_eff  (cause_eff),
    .epc_eff    (epc_eff)
  );

  // Decide whether the MEM instruction raises an event and which one wins.
  always_comb begin
    exl         = status_eff[1];
    irq_pending = status_eff[0] && !exl && (|(cause_eff[15:8] & status_eff[15:8]));
    take_exc    = 1'b0;
    take_eret   = 1'b0;
    code_sel    = EXC_CODE_INT;
    if (state == IDLE && mem_valid_i) begin
      if (irq_pending) begin
        take_exc = 1'b1;
        code_sel = EXC_CODE_INT;
      end else if (mem_exc_i[EXC_BIT_SYSCALL]) begin
        take_exc = 1'b1;
        code_sel = EXC_CODE_SYS;
      end else if (mem_exc_i[EXC_BIT_RI]) begin
        take_exc = 1'b1;
        code_sel = EXC_CODE_RI;
      end else if (mem_exc_i[EXC_BIT_TRAP]) begin
        take_exc = 1'b1;
        code_sel = EXC_CODE_TR;
      end else if (mem_exc_i[EXC_BIT_OV]) begin
        take_exc = 1'b1;
        code_sel = EXC_CODE_OV;
      end else if (mem_exc_i[EXC_BIT_ERET]) begin
        take_eret = 1'b1;
      end
    end
  end

  // State register and drain counter; reset aborts any flush/drain in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      drain_count <= 3'd0;
    end else begin
      state <= state_next;
      case (state)
        FLUSH:   drain_count <= DRAIN_LOAD;
        DRAIN:   if (drain_count != 3'd0) drain_count <= drain_count - 3'd1;
        default: ;
      endcase
    end
  end

  // Next-state: one flush cycle, then DRAIN_CYCLES of ignoring MEM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_exc || take_eret) state_next = FLUSH;
      FLUSH:   state_next = DRAIN;
      DRAIN:   if (drain_count <= 3'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next output values: pulses only on an accepted event, data outputs hold otherwise.
  always_comb begin
    flush_nxt  = take_exc || take_eret;
    eret_nxt   = take_eret;
    exc_we_nxt = take_exc;
    epc_we_nxt = take_exc && !exl;
    new_pc_nxt = new_pc_o;
    code_nxt   = exc_code_o;
    epc_nxt    = exc_epc_o;
    bd_nxt     = exc_bd_o;
    if (take_exc) begin
      new_pc_nxt = EXC_VECTOR;
      code_nxt   = code_sel;
      if (!exl) begin
        bd_nxt  = mem_is_delayslot_i;
        epc_nxt = mem_is_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
      end
    end else if (take_eret) begin
      new_pc_nxt = epc_eff;
    end
  end

  // Output registers so nothing reaches the outputs combinationally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_o      <= 1'b0;
      new_pc_o     <= 32'd0;
      exc_we_o     <= 1'b0;
      exc_code_o   <= 5'd0;
      exc_epc_we_o <= 1'b0;
      exc_epc_o    <= 32'd0;
      exc_bd_o     <= 1'b0;
      eret_o       <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      flush_o      <= flush_nxt;
      new_pc_o     <= new_pc_nxt;
      exc_we_o     <= exc_we_nxt;
      exc_code_o   <= code_nxt;
      exc_epc_we_o <= epc_we_nxt;
      exc_epc_o    <= epc_nxt;
      exc_bd_o     <= bd_nxt;
      eret_o       <= eret_nxt;
      busy_o       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomized and directed bench for exception_ctrl against a behavioural model.
module tb_exception_ctrl;

  localparam int DRAIN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_is_delayslot_i;
  logic [4:0]  mem_exc_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic        flush_o, exc_we_o, exc_epc_we_o, exc_bd_o, eret_o, busy_o;
  logic [31:0] new_pc_o, exc_epc_o;
  logic [4:0]  exc_code_o;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: expected outputs after the most recent edge.
  int          mBlocked;
  logic        mFlush, mEret, mExcWe, mEpcWe, mBd;
  logic [31:0] mNewPc, mEpc;
  logic [4:0]  mCode;

  exception_ctrl #(.EXC_VECTOR(32'h0000_0020), .DRAIN_CYCLES(DRAIN)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_pc_i           (mem_pc_i),
    .mem_is_delayslot_i (mem_is_delayslot_i),
    .mem_exc_i          (mem_exc_i),
    .cp0_status_i       (cp0_status_i),
    .cp0_cause_i        (cp0_cause_i),
    .cp0_epc_i          (cp0_epc_i),
    .wb_cp0_we_i        (wb_cp0_we_i),
    .wb_cp0_waddr_i     (wb_cp0_waddr_i),
    .wb_cp0_data_i      (wb_cp0_data_i),
    .flush_o            (flush_o),
    .new_pc_o           (new_pc_o),
    .exc_we_o           (exc_we_o),
    .exc_code_o         (exc_code_o),
    .exc_epc_we_o       (exc_epc_we_o),
    .exc_epc_o          (exc_epc_o),
    .exc_bd_o           (exc_bd_o),
    .eret_o             (eret_o),
    .busy_o             (busy_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model of one clock edge, built from the architectural rules.
  task automatic modelStep();
    logic [31:0] st, ca, ep;
    logic        irq, isExc;
    logic [4:0]  code;
    if (!rst) begin
      mBlocked = 0;
      {mFlush, mEret, mExcWe, mEpcWe, mBd} = '0;
      mNewPc = 0; mEpc = 0; mCode = 0;
      return;
    end
    {mFlush, mEret, mExcWe, mEpcWe} = '0;
    if (mBlocked > 0) begin
      mBlocked--;
      return;
    end
    if (!mem_valid_i) return;
    st = cp0_status_i; ca = cp0_cause_i; ep = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ep = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13)
      ca = (cp0_cause_i & ~32'h00C0_0300) | (wb_cp0_data_i & 32'h00C0_0300);
    irq = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
    isExc = 1'b1;
    code = 5'h00;
    if (irq) code = 5'h00;
    else if (mem_exc_i[0]) code = 5'h08;
    else if (mem_exc_i[1]) code = 5'h0a;
    else if (mem_exc_i[2]) code = 5'h0d;
    else if (mem_exc_i[3]) code = 5'h0c;
    else isExc = 1'b0;
    if (isExc) begin
      mFlush = 1; mExcWe = 1; mCode = code; mNewPc = 32'h20;
      if (!st[1]) begin
        mEpcWe = 1;
        mBd = mem_is_delayslot_i;
        mEpc = mem_is_delayslot_i ? mem_pc_i - 32'd4 : mem_pc_i;
      end
      mBlocked = 1 + DRAIN;
    end else if (mem_exc_i[4]) begin
      mFlush = 1; mEret = 1; mNewPc = ep;
      mBlocked = 1 + DRAIN;
    end
  endtask

  // Compare every DUT output with the model.
  task automatic compareAll();
    checkOutput("flush", 32'(flush_o), 32'(mFlush));
    checkOutput("new_pc", new_pc_o, mNewPc);
    checkOutput("exc_we", 32'(exc_we_o), 32'(mExcWe));
    checkOutput("exc_code", 32'(exc_code_o), 32'(mCode));
    checkOutput("epc_we", 32'(exc_epc_we_o), 32'(mEpcWe));
    checkOutput("exc_epc", exc_epc_o, mEpc);
    checkOutput("exc_bd", 32'(exc_bd_o), 32'(mBd));
    checkOutput("eret", 32'(eret_o), 32'(mEret));
    checkOutput("busy", 32'(busy_o), 32'(mBlocked > 0));
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] pc, input logic ds,
                               input logic [4:0] exc, input logic [31:0] st, input logic [31:0] ca,
                               input logic [31:0] ep, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd);
    rst = r; mem_valid_i = v; mem_pc_i = pc; mem_is_delayslot_i = ds; mem_exc_i = exc;
    cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = ep;
    wb_cp0_we_i = we; wb_cp0_waddr_i = wa; wb_cp0_data_i = wd;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [4:0] exc, wa;
    int r;

    // Reset
    applyStimulus(0, 1, 32'h1234, 0, 5'h1f, 32'h1, 32'hff00, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_flush", 32'(flush_o), 0);
    checkOutput("reset_busy", 32'(busy_o), 0);

    // Overflow, not in delay slot
    applyStimulus(1, 1, 32'h1000, 0, 5'b01000, 0, 0, 0, 0, 0, 0);
    checkOutput("ov_flush", 32'(flush_o), 1);
    checkOutput("ov_newpc", new_pc_o, 32'h20);
    checkOutput("ov_code", 32'(exc_code_o), 32'h0c);
    checkOutput("ov_epc", exc_epc_o, 32'h1000);
    checkOutput("ov_epcwe", 32'(exc_epc_we_o), 1);
    idleCycles(2);

    // Syscall in delay slot, then wrap of pc-4
    applyStimulus(1, 1, 32'h2004, 1, 5'b00001, 0, 0, 0, 0, 0, 0);
    checkOutput("sys_epc", exc_epc_o, 32'h2000);
    checkOutput("sys_bd", 32'(exc_bd_o), 1);
    checkOutput("sys_code", 32'(exc_code_o), 32'h08);
    idleCycles(2);
    applyStimulus(1, 1, 32'h0, 1, 5'b00001, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_epc", exc_epc_o, 32'hFFFF_FFFC);
    idleCycles(2);

    // Interrupt masked by same-cycle mtc0 STATUS, then taken without it
    applyStimulus(1, 1, 32'h500, 0, 0, 32'h0000_0401, 32'h0000_0400, 0, 1, 5'd12, 32'h0000_0400);
    checkOutput("irq_fwd_flush", 32'(flush_o), 0);
    applyStimulus(1, 1, 32'h500, 0, 0, 32'h0000_0401, 32'h0000_0400, 0, 0, 5'd12, 32'h0000_0400);
    checkOutput("irq_flush", 32'(flush_o), 1);
    checkOutput("irq_code", 32'(exc_code_o), 0);
    idleCycles(2);

    // ERET with same-cycle mtc0 EPC
    applyStimulus(1, 1, 32'h600, 0, 5'b10000, 32'h2, 0, 32'h1111, 1, 5'd14, 32'h3000);
    checkOutput("eret_newpc", new_pc_o, 32'h3000);
    checkOutput("eret_pulse", 32'(eret_o), 1);
    checkOutput("eret_excwe", 32'(exc_we_o), 0);
    idleCycles(2);

    // Back-to-back: overflow then trap held
    applyStimulus(1, 1, 32'h700, 0, 5'b01000, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h704, 0, 5'b00100, 0, 0, 0, 0, 0, 0);
    checkOutput("b2b_ignored", 32'(flush_o), 0);
    applyStimulus(1, 1, 32'h704, 0, 5'b00100, 0, 0, 0, 0, 0, 0);
    checkOutput("b2b_drain", 32'(flush_o), 0);
    applyStimulus(1, 1, 32'h704, 0, 5'b00100, 0, 0, 0, 0, 0, 0);
    checkOutput("b2b_trap_flush", 32'(flush_o), 1);
    checkOutput("b2b_trap_code", 32'(exc_code_o), 32'h0d);
    idleCycles(2);

    // Nested trap with EXL set
    applyStimulus(1, 1, 32'h800, 0, 5'b00100, 32'h2, 0, 0, 0, 0, 0);
    checkOutput("nest_excwe", 32'(exc_we_o), 1);
    checkOutput("nest_epcwe", 32'(exc_epc_we_o), 0);
    checkOutput("nest_epc_held", exc_epc_o, 32'h704);
    idleCycles(2);

    // Reset during FLUSH
    applyStimulus(1, 1, 32'h900, 0, 5'b01000, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_flush_newpc", new_pc_o, 0);
    checkOutput("rst_flush_busy", 32'(busy_o), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) exc = 5'd0;
      else if (r == 1) exc = 5'(1 << $urandom_range(0, 4));
      else exc = 5'($urandom);
      r = $urandom_range(0, 3);
      if (r == 0) wa = 5'd12;
      else if (r == 1) wa = 5'd13;
      else if (r == 2) wa = 5'd14;
      else wa = 5'($urandom);
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom,
                    1'($urandom), exc, $urandom, $urandom, $urandom,
                    1'($urandom), wa, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
